// File: rtl/en_counter_if.sv
// Bus bundle for en_counter: count enable in, count value and status flags out.
interface en_counter_if #(
    parameter int unsigned width = 8
);
    logic             en;
    logic [width-1:0] count;
    logic             tc;
    logic             wrap;
    logic             overflow;

    // Controller side: drives the enable, observes count and status.
    modport master (output en, input count, tc, wrap, overflow);

    // Counter side: samples the enable, produces count and status.
    modport slave  (input en, output count, tc, wrap, overflow);
endinterface

// File: rtl/en_counter.sv
// Enable-gated binary up-counter with programmable terminal count,
// combinational terminal-count flag, one-cycle wrap pulse and sticky overflow.
module en_counter #(
    parameter int unsigned     width     = 8,
    parameter longint unsigned max_value = (64'd1 << width) - 64'd1
) (
    input  logic         clk,
    input  logic         rst,
    en_counter_if.slave  bus
);

    // Elaboration-time guard on the parameter ranges and the bus width.
    if (width < 1 || width > 32 || max_value == 64'd0 ||
        max_value > ((64'd1 << width) - 64'd1) || $bits(bus.count) != width) begin : g_bad_params
        $error("en_counter: illegal parameters width=%0d max_value=%0d", width, max_value);
    end

    localparam logic [width-1:0] max_count = width'(max_value);

    logic [width-1:0] count_q;
    logic             wrap_q;
    logic             overflow_q;

    // Count register with wrap pulse and sticky overflow; async clear on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.en) begin
                if (count_q == max_count) begin
                    count_q    <= '0;
                    wrap_q     <= 1'b1;
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + width'(1);
                end
            end
        end
    end

    // Terminal count decodes the registered count only, independent of en.
    always_comb begin
        bus.tc = (count_q == max_count);
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_en_counter.sv
// Bench for en_counter: a full-range 8-bit instance and a modulus-10 4-bit
// instance run side by side against an edge-counting reference model.
module tb_en_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    en_counter_if #(.width(8)) bus8 ();
    en_counter_if #(.width(4)) bus4 ();

    en_counter #(.width(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    en_counter #(.width(4), .max_value(9)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Reference model: enabled edges since reset, and whether the latest edge wrapped.
    int unsigned n8 = 0;
    int unsigned n4 = 0;
    bit          w8 = 1'b0;
    bit          w4 = 1'b0;

    localparam int unsigned mod8 = 256;
    localparam int unsigned mod4 = 10;

    int unsigned passes = 0;
    int unsigned checks = 0;
    int unsigned wraps4 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("count8",    32'(bus8.count),    n8 % mod8);
        chk("tc8",       32'(bus8.tc),       32'((n8 % mod8) == mod8 - 1));
        chk("wrap8",     32'(bus8.wrap),     32'(w8));
        chk("overflow8", 32'(bus8.overflow), 32'(n8 >= mod8));
        chk("count4",    32'(bus4.count),    n4 % mod4);
        chk("tc4",       32'(bus4.tc),       32'((n4 % mod4) == mod4 - 1));
        chk("wrap4",     32'(bus4.wrap),     32'(w4));
        chk("overflow4", 32'(bus4.overflow), 32'(n4 >= mod4));
    endtask

    task automatic model_reset();
        n8 = 0; n4 = 0; w8 = 1'b0; w4 = 1'b0;
    endtask

    // One clock edge: drive enables, advance the model, check one step later.
    task automatic tick(input logic e8, input logic e4);
        bus8.en = e8;
        bus4.en = e4;
        @(posedge clk);
        if (!rst) begin
            if (e8) n8++;
            if (e4) n4++;
            w8 = e8 && (n8 % mod8 == 0);
            w4 = e4 && (n4 % mod4 == 0);
        end
        #1;
        check_all();
        if (bus4.wrap) wraps4++;
    endtask

    // Assert reset between edges, confirm immediate clear, release between edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        bus8.en = 1'b0;
        bus4.en = 1'b0;
        #1;
        check_all();

        // Reset held 10 cycles with en low, then 5 idle cycles.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

        // Basic count: 50 enabled edges, then hold for 10.
        for (int i = 0; i < 50; i++) tick(1'b1, 1'($urandom_range(1)));
        for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom_range(1)));
        chk("basic_count50", 32'(bus8.count), 32'd50);

        // Enable gating pattern 1,0,1,1,0 from zero.
        pulse_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("gating_count3", 32'(bus8.count), 32'd3);

        // Natural rollover of the 8-bit instance.
        pulse_reset();
        for (int i = 0; i < 255; i++) tick(1'b1, 1'b0);
        chk("rollover_tc_at_255", 32'(bus8.tc), 32'd1);
        tick(1'b1, 1'b0);
        chk("rollover_wrap", 32'(bus8.wrap), 32'd1);
        tick(1'b0, 1'b0);
        chk("rollover_wrap_one_cycle", 32'(bus8.wrap), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'(i % 2), 1'b0);
        chk("rollover_overflow_sticky", 32'(bus8.overflow), 32'd1);

        // Modulus 10 on the 4-bit instance: 25 enabled edges.
        pulse_reset();
        wraps4 = 0;
        for (int i = 0; i < 25; i++) tick(1'($urandom_range(1)), 1'b1);
        chk("mod_final_count5", 32'(bus4.count), 32'd5);
        chk("mod_wrap_pulses2", wraps4, 32'd2);
        chk("mod_overflow", 32'(bus4.overflow), 32'd1);

        // Asynchronous reset at count 37 with en high.
        pulse_reset();
        for (int i = 0; i < 37; i++) tick(1'b1, 1'b1);
        chk("async_pre_count37", 32'(bus8.count), 32'd37);
        bus8.en = 1'b1;
        pulse_reset();
        chk("async_count_cleared", 32'(bus8.count), 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        chk("async_resume_count4", 32'(bus8.count), 32'd4);

        // Randomized enables with occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199) == 0) pulse_reset();
            else tick(1'($urandom_range(3) != 0), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
